// File: rtl/lt24_lcd_reset_sequencer.sv
// rtl/lt24_lcd_reset_sequencer.sv - Avalon-MM master sequencing the LT24 LCD_RESET_N power-up pulse
//
// Drives the LCD_RESET_N PIO slave (bit0 of register 0) high, low, high, then
// waits for the panel to settle before reporting done. Software starts the LCD
// init driver on done instead of busy-waiting.
//
// Optional feature macro: LCD_RST_READBACK_EN
//   When defined, each accepted write is followed by a read of the PIO; a
//   readback mismatch parks the FSM in FAIL with error=1 until start or reset.
//
// Ports:
//   clk, reset_n       system clock, synchronous active-low reset
//   start              1-cycle request to run the sequence (IDLE/DONE/FAIL only)
//   busy, done, error  status; done held until next start/reset
//   avm_*              Avalon-MM master to the PIO slave (address always 0)

module lt24_lcd_reset_sequencer #(
  parameter int T_PRE_CYC  = 50000,
  parameter int T_LOW_CYC  = 500,
  parameter int T_POST_CYC = 6000000,
  parameter int CNT_W      = 23,
  parameter int AUTO_START = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  avm_address,
  output logic        avm_chipselect,
  output logic        avm_write_n,
  output logic        avm_read_n,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  // A wait of T cycles loads T-1 and exits on the cycle the counter reads 0;
  // a zero length is stretched to one cycle.
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'((T_PRE_CYC  > 0) ? T_PRE_CYC  - 1 : 0);
  localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'((T_LOW_CYC  > 0) ? T_LOW_CYC  - 1 : 0);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'((T_POST_CYC > 0) ? T_POST_CYC - 1 : 0);

  typedef enum logic [3:0] {
    IDLE,
    WR_HI1,
    WAIT_PRE,
    WR_LO,
    WAIT_LOW,
    WR_HI2,
    WAIT_POST,
    DONE
`ifdef LCD_RST_READBACK_EN
    ,
    RD_HI1,
    RD_LO,
    RD_HI2,
    FAIL
`endif
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             auto_pend;  // set by reset, cleared on the first edge out of reset

  // Only bit0 of the readback carries information.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;

  assign avm_address = 2'd0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      auto_pend <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      auto_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    busy           = 1'b0;
    done           = 1'b0;
    error          = 1'b0;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_read_n     = 1'b1;
    avm_writedata  = 32'd0;

    case (state)
      IDLE: begin
        if (start || ((AUTO_START != 0) && auto_pend)) state_nx = WR_HI1;
      end

      WR_HI1: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = 32'd1;
        if (!avm_waitrequest) begin
`ifdef LCD_RST_READBACK_EN
          state_nx = RD_HI1;
`else
          state_nx = WAIT_PRE;
          cnt_nx   = PRE_LD;
`endif
        end
      end

      WAIT_PRE: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = WR_LO;
        else           cnt_nx   = cnt - CNT_W'(1);
      end

      WR_LO: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = 32'd0;
        if (!avm_waitrequest) begin
`ifdef LCD_RST_READBACK_EN
          state_nx = RD_LO;
`else
          state_nx = WAIT_LOW;
          cnt_nx   = LOW_LD;
`endif
        end
      end

      WAIT_LOW: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = WR_HI2;
        else           cnt_nx   = cnt - CNT_W'(1);
      end

      WR_HI2: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = 32'd1;
        if (!avm_waitrequest) begin
`ifdef LCD_RST_READBACK_EN
          state_nx = RD_HI2;
`else
          state_nx = WAIT_POST;
          cnt_nx   = POST_LD;
`endif
        end
      end

      WAIT_POST: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = DONE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end

      DONE: begin
        done = 1'b1;
        if (start) state_nx = WR_HI1;
      end

`ifdef LCD_RST_READBACK_EN
      RD_HI1: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_read_n     = 1'b0;
        if (!avm_waitrequest) begin
          if (avm_readdata[0]) begin
            state_nx = WAIT_PRE;
            cnt_nx   = PRE_LD;
          end else begin
            state_nx = FAIL;
          end
        end
      end

      RD_LO: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_read_n     = 1'b0;
        if (!avm_waitrequest) begin
          if (!avm_readdata[0]) begin
            state_nx = WAIT_LOW;
            cnt_nx   = LOW_LD;
          end else begin
            state_nx = FAIL;
          end
        end
      end

      RD_HI2: begin
        busy           = 1'b1;
        avm_chipselect = 1'b1;
        avm_read_n     = 1'b0;
        if (!avm_waitrequest) begin
          if (avm_readdata[0]) begin
            state_nx = WAIT_POST;
            cnt_nx   = POST_LD;
          end else begin
            state_nx = FAIL;
          end
        end
      end

      FAIL: begin
        error = 1'b1;
        if (start) state_nx = WR_HI1;
      end
`endif

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lt24_lcd_reset_sequencer.sv
// tb/tb_lt24_lcd_reset_sequencer.sv - self-checking bench for lt24_lcd_reset_sequencer

module tb_lt24_lcd_reset_sequencer;

  localparam int TP = 4;
  localparam int TL = 3;
  localparam int TQ = 5;
`ifdef LCD_RST_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Main instance (AUTO_START=0)
  logic        reset_n, start, waitreq;
  logic [31:0] readdata;
  logic        busy, done, error, cs, wn, rn;
  logic [1:0]  addr;
  logic [31:0] wd;

  // Auto-start instance (AUTO_START=1)
  logic        reset_n_a, start_a, waitreq_a;
  logic [31:0] readdata_a;
  logic        busy_a, done_a, error_a, cs_a, wn_a, rn_a;
  logic [1:0]  addr_a;
  logic [31:0] wd_a;

  lt24_lcd_reset_sequencer #(
    .T_PRE_CYC(TP), .T_LOW_CYC(TL), .T_POST_CYC(TQ), .CNT_W(8), .AUTO_START(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .busy(busy), .done(done), .error(error),
    .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wn), .avm_read_n(rn),
    .avm_writedata(wd), .avm_readdata(readdata), .avm_waitrequest(waitreq)
  );

  lt24_lcd_reset_sequencer #(
    .T_PRE_CYC(TP), .T_LOW_CYC(TL), .T_POST_CYC(TQ), .CNT_W(8), .AUTO_START(1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n_a), .start(start_a),
    .busy(busy_a), .done(done_a), .error(error_a),
    .avm_address(addr_a), .avm_chipselect(cs_a), .avm_write_n(wn_a), .avm_read_n(rn_a),
    .avm_writedata(wd_a), .avm_readdata(readdata_a), .avm_waitrequest(waitreq_a)
  );

  // PIO slave models: LCD_RESET_N level updates on every accepted write.
  logic lvl   = 1'b1;
  logic lvl_a = 1'b1;
  bit   bad_slave = 1'b0;
  logic wr_log[$];

  always @(posedge clk) begin
    if (cs && !wn && !waitreq) begin
      lvl <= wd[0];
      wr_log.push_back(wd[0]);
    end
    if (cs_a && !wn_a && !waitreq_a) lvl_a <= wd_a[0];
  end
  assign readdata   = {31'b0, bad_slave ? 1'b0 : lvl};
  assign readdata_a = {31'b0, lvl_a};

  // Expected per-cycle view: {busy,done,error,cs,write_n,read_n,address,writedata}
  logic [39:0] exp_v [0:63];
  bit          exp_w [0:63];
  int          nwin;

  function automatic logic [39:0] mk(bit b, bit d, bit e, bit c, bit w, bit r, logic [31:0] dat);
    return {b, d, e, c, w, r, 2'b00, dat};
  endfunction

  function automatic logic [39:0] obs_m();
    return {busy, done, error, cs, wn, rn, addr, (wn ? 32'h0 : wd)};
  endfunction
  function automatic logic [39:0] obs_a();
    return {busy_a, done_a, error_a, cs_a, wn_a, rn_a, addr_a, (wn_a ? 32'h0 : wd_a)};
  endfunction
  function automatic logic [39:0] raw_m();
    return {busy, done, error, cs, wn, rn, addr, wd};
  endfunction
  function automatic logic [39:0] raw_a();
    return {busy_a, done_a, error_a, cs_a, wn_a, rn_a, addr_a, wd_a};
  endfunction

  // Phase list: write L (stalled s cycles), optional readback, wait T; then done.
  task automatic build(input int s0, input int s1, input int s2);
    int s [3];
    int t [3];
    bit l [3];
    int n;
    s = '{s0, s1, s2};
    t = '{TP, TL, TQ};
    l = '{1'b1, 1'b0, 1'b1};
    n = 0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j <= s[k]; j++) begin
        exp_v[n] = mk(1, 0, 0, 1, 0, 1, {31'b0, l[k]});
        exp_w[n] = (j < s[k]);
        n++;
      end
      if (RB != 0) begin
        exp_v[n] = mk(1, 0, 0, 1, 1, 0, 32'h0);
        exp_w[n] = 1'b0;
        n++;
      end
      for (int j = 0; j < t[k]; j++) begin
        exp_v[n] = mk(1, 0, 0, 0, 1, 1, 32'h0);
        exp_w[n] = 1'b0;
        n++;
      end
    end
    nwin = n;
    for (int j = 0; j < 4; j++) begin
      exp_v[n] = mk(0, 1, 0, 0, 1, 1, 32'h0);
      exp_w[n] = 1'b0;
      n++;
    end
  endtask

  // Called right after a negedge. which=0 pulses start; which=1 relies on the
  // auto instance having just left reset.
  task automatic run_trace(input bit which, input int s0, input int s1, input int s2,
                           input int spur, input string name);
    logic [39:0] got;
    int first_done, lows, w0, exp_lat, exp_low;
    bit lvl0;
    build(s0, s1, s2);
    lvl0 = which ? lvl_a : lvl;
    w0 = wr_log.size();
    first_done = -1;
    lows = 0;
    if (which) waitreq_a = 1'b0;
    else begin
      waitreq = 1'b0;
      start   = 1'b1;
    end
    for (int n = 0; n < nwin + 4; n++) begin
      @(negedge clk);
      start = (!which && n == spur);
      if (which) waitreq_a = exp_w[n];
      else       waitreq   = exp_w[n];
      got = which ? obs_a() : obs_m();
      if (got[38] && first_done < 0) first_done = n;
      if (n < nwin && ((which ? lvl_a : lvl) == 1'b0)) lows++;
      checks++;
      if (got !== exp_v[n]) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h expected=%h", name, n, got, exp_v[n]);
      end
    end
    start = 1'b0;
    exp_lat = 3 + 3 * RB + TP + TL + TQ + s0 + s1 + s2;
    checks++;
    if (first_done !== exp_lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d expected=%0d", name, first_done, exp_lat);
    end
    exp_low = (lvl0 ? 0 : s0 + 1) + TL + 1 + RB + s2;
    checks++;
    if (lows !== exp_low) begin
      failures++;
      $display("FAIL %s_low_width got=%0d expected=%0d", name, lows, exp_low);
    end
    if (!which) begin
      checks++;
      if (wr_log.size() != w0 + 3 || wr_log[w0] !== 1'b1 || wr_log[w0+1] !== 1'b0 ||
          wr_log[w0+2] !== 1'b1) begin
        failures++;
        $display("FAIL %s_writes got_count=%0d expected_count=3 (values 1,0,1)",
                 name, wr_log.size() - w0);
      end
    end
  endtask

  task automatic check_reset_vals(input bit which, input string name);
    logic [39:0] got;
    got = which ? raw_a() : raw_m();
    checks++;
    if (got !== mk(0, 0, 0, 0, 1, 1, 32'h0)) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, mk(0, 0, 0, 0, 1, 1, 32'h0));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reset_n_a = 1'b0; start = 1'b0; start_a = 1'b0;
    waitreq = 1'b0; waitreq_a = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "reset_main");
    check_reset_vals(1, "reset_auto");
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_reset_vals(0, "idle_no_autostart");
    end
  endtask

  task automatic test_basic();
    run_trace(0, 0, 0, 0, -1, "basic");
  endtask

  task automatic test_stall_lo();
    run_trace(0, 0, 3, 0, -1, "stall_wr_lo");
  endtask

  task automatic test_start_while_busy();
    run_trace(0, 0, 0, 0, 5, "start_busy");
    run_trace(0, 1, 0, 2, 9, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_trace(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(1, 12), "random");
    end
  endtask

  task automatic test_auto_start();
    reset_n_a = 1'b1;
    run_trace(1, 0, 0, 0, -1, "auto_start");
  endtask

  // Abort in WAIT_LOW (second cycle of it) for either instance.
  task automatic test_reset_abort();
    int ab;
    ab = 7 + 2 * RB;
    start = 1'b1; waitreq = 1'b0;
    for (int n = 0; n <= ab; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_vals(0, "abort_main");
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_vals(0, "abort_main_idle");
    end
    run_trace(0, 0, 0, 0, -1, "after_abort_main");

    reset_n_a = 1'b0;
    @(negedge clk);
    reset_n_a = 1'b1;
    for (int n = 0; n <= ab; n++) @(negedge clk);
    reset_n_a = 1'b0;
    @(negedge clk);
    check_reset_vals(1, "abort_auto");
    reset_n_a = 1'b1;
    run_trace(1, 0, 0, 0, -1, "after_abort_auto");
  endtask

`ifdef LCD_RST_READBACK_EN
  task automatic test_readback_fail();
    int w0;
    logic [39:0] got;
    w0 = wr_log.size();
    bad_slave = 1'b1;
    start = 1'b1; waitreq = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n >= 2) begin
        got = obs_m();
        checks++;
        if (got !== mk(0, 0, 1, 0, 1, 1, 32'h0)) begin
          failures++;
          $display("FAIL readback_fail cycle=%0d got=%h expected=%h", n, got,
                   mk(0, 0, 1, 0, 1, 1, 32'h0));
        end
      end
    end
    checks++;
    if (wr_log.size() != w0 + 1) begin
      failures++;
      $display("FAIL readback_fail_writes got=%0d expected=1", wr_log.size() - w0);
    end
    bad_slave = 1'b0;
    run_trace(0, 0, 0, 0, -1, "rerun_after_fail");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall_lo();
    test_start_while_busy();
    test_random();
    test_auto_start();
    test_reset_abort();
`ifdef LCD_RST_READBACK_EN
    test_readback_fail();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Read and write strobes must never overlap on either instance.
  always @(negedge clk) begin
    if ((!wn && !rn) || (!wn_a && !rn_a)) begin
      $display("FAIL strobe_overlap main=%b%b auto=%b%b required=not both low", wn, rn, wn_a, rn_a);
    end
  end

endmodule
